// File: rtl/mc_control_fsm.sv
// ---------------------------------------------------------------------------
// mc_control_fsm
//
// Multi-cycle MIPS main control unit. A Moore FSM steps each instruction
// through fetch / decode / execute / memory / writeback and drives the
// datapath mux selects and register enables from the registered state.
// Memory states (FETCH, MEMRD, MEMWR) stall on mem_ready. A bounded wait
// counter turns a stuck memory into a sticky bus error.
//
// Optional feature macro: ILLEGAL_TRAP_EN
//   defined   : unknown opcode in DECODE -> TRAP, illegal_op port present
//   undefined : unknown opcode is a NOP (DECODE -> FETCH, instr_done=1)
//
// Parameters:
//   MEM_TIMEOUT  max cycles a memory state waits on mem_ready (2..256)
//   CNT_W        wait-counter width, 2**CNT_W >= MEM_TIMEOUT
//   STATE_W      width of the state debug output
//
// Ports:
//   clk, reset        clock (rising edge), async active-high reset
//   opcode            IR[31:26], sampled in DECODE and MEMADR only
//   mem_ready         memory completes the current access this cycle
//   pc_write          unconditional PC load
//   pc_write_cond     PC load if ALU zero
//   pc_src            00 ALU, 01 ALUOut, 10 jump target
//   iord              0 = PC address, 1 = ALUOut address
//   mem_read          memory read strobe
//   mem_write         memory write strobe
//   ir_write          IR load enable
//   mem_to_reg        writeback source: 1 = MDR, 0 = ALUOut
//   reg_dst           1 = rd, 0 = rt
//   reg_write         register file write enable
//   alu_src_a         0 = PC, 1 = A
//   alu_src_b         00 B, 01 4, 10 imm, 11 imm<<2
//   alu_op            00 add, 01 sub, 10 funct-decoded
//   instr_done        high in the final state of each instruction
//   bus_error         sticky memory-timeout flag
//   illegal_op        (ILLEGAL_TRAP_EN only) high in TRAP
//   state             current state encoding (debug)
// ---------------------------------------------------------------------------
module mc_control_fsm #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8,
    parameter int STATE_W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic [1:0]         pc_src,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic               instr_done,
    output logic               bus_error,
`ifdef ILLEGAL_TRAP_EN
    output logic               illegal_op,
`endif
    output logic [STATE_W-1:0] state
);

    // State encodings
    localparam logic [3:0] S_INIT   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_MEMADR = 4'd3;
    localparam logic [3:0] S_MEMRD  = 4'd4;
    localparam logic [3:0] S_MEMWB  = 4'd5;
    localparam logic [3:0] S_MEMWR  = 4'd6;
    localparam logic [3:0] S_EXEC   = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;
    localparam logic [3:0] S_JUMP   = 4'd10;
    localparam logic [3:0] S_ADDIEX = 4'd11;
    localparam logic [3:0] S_ADDIWB = 4'd12;
    localparam logic [3:0] S_ERROR  = 4'd13;
    localparam logic [3:0] S_TRAP   = 4'd14;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // Last counter value before a wait times out.
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    logic [3:0]       state_q,     state_d;
    logic [CNT_W-1:0] wait_cnt_q,  wait_cnt_d;
    logic             bus_error_q, bus_error_d;

    logic             op_known;
    logic [3:0]       decode_next;
    logic             wait_expired;

    // -----------------------------------------------------------------------
    // Opcode dispatch out of DECODE
    // -----------------------------------------------------------------------
    always_comb begin
        op_known    = 1'b1;
        decode_next = S_FETCH;
        case (opcode)
            OP_RTYPE:      decode_next = S_EXEC;
            OP_LW, OP_SW:  decode_next = S_MEMADR;
            OP_BEQ:        decode_next = S_BRANCH;
            OP_J:          decode_next = S_JUMP;
            OP_ADDI:       decode_next = S_ADDIEX;
            default: begin
                op_known = 1'b0;
`ifdef ILLEGAL_TRAP_EN
                decode_next = S_TRAP;
`else
                decode_next = S_FETCH;
`endif
            end
        endcase
    end

    assign wait_expired = (wait_cnt_q == WAIT_LAST);

    // -----------------------------------------------------------------------
    // Next-state, wait counter and sticky error
    // The counter defaults to zero, so it clears on any state change and
    // on mem_ready; it only counts while a memory state is being held.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = '0;
        bus_error_d = bus_error_q;
        case (state_q)
            S_INIT:   state_d = S_FETCH;
            S_FETCH, S_MEMRD, S_MEMWR: begin
                if (mem_ready) begin
                    // A ready on the last allowed cycle still completes.
                    if (state_q == S_FETCH)      state_d = S_DECODE;
                    else if (state_q == S_MEMRD) state_d = S_MEMWB;
                    else                         state_d = S_FETCH;
                end else if (wait_expired) begin
                    state_d     = S_ERROR;
                    bus_error_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_DECODE: state_d = decode_next;
            S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMWB:  state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            S_ERROR:  state_d = S_ERROR;
`ifdef ILLEGAL_TRAP_EN
            S_TRAP:   state_d = S_TRAP;
`endif
            // Unused encodings recover through INIT.
            default:  state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_INIT;
            wait_cnt_q  <= '0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            bus_error_q <= bus_error_d;
        end
    end

    // -----------------------------------------------------------------------
    // Output decode from the registered state. FETCH ir/pc load and the
    // MEMWR completion flag are qualified by mem_ready so a stalled access
    // never commits.
    // -----------------------------------------------------------------------
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 2'b00;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        instr_done    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
`ifndef ILLEGAL_TRAP_EN
                // Unknown opcode retires here as a NOP.
                instr_done = ~op_known;
`endif
            end
            S_MEMADR, S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                mem_write  = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ready;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_src        = 2'b01;
                instr_done    = 1'b1;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_src     = 2'b10;
                instr_done = 1'b1;
            end
            S_ADDIWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus_error = bus_error_q;
    assign state     = STATE_W'(state_q);

`ifdef ILLEGAL_TRAP_EN
    assign illegal_op = (state_q == S_TRAP);
`else
    // op_known only feeds the NOP completion flag in this build.
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
module tb_mc_control_fsm;

    localparam logic [3:0] S_INIT   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_MEMADR = 4'd3;
    localparam logic [3:0] S_MEMRD  = 4'd4;
    localparam logic [3:0] S_MEMWB  = 4'd5;
    localparam logic [3:0] S_MEMWR  = 4'd6;
    localparam logic [3:0] S_EXEC   = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;
    localparam logic [3:0] S_JUMP   = 4'd10;
    localparam logic [3:0] S_ADDIEX = 4'd11;
    localparam logic [3:0] S_ADDIWB = 4'd12;
    localparam logic [3:0] S_ERROR  = 4'd13;
    localparam logic [3:0] S_TRAP   = 4'd14;

    // ctrl = {pc_write, pc_write_cond, pc_src, iord, mem_read, mem_write,
    //         ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
    //         alu_src_b, alu_op, instr_done, bus_error}
    localparam logic [17:0] C_ZERO    = 18'b0_0_00_0_0_0_0_0_0_0_0_00_00_0_0;
    localparam logic [17:0] C_FETCH_R = 18'b1_0_00_0_1_0_1_0_0_0_0_01_00_0_0;
    localparam logic [17:0] C_FETCH_W = 18'b0_0_00_0_1_0_0_0_0_0_0_01_00_0_0;
    localparam logic [17:0] C_DEC     = 18'b0_0_00_0_0_0_0_0_0_0_0_11_00_0_0;
    localparam logic [17:0] C_DEC_NOP = 18'b0_0_00_0_0_0_0_0_0_0_0_11_00_1_0;
    localparam logic [17:0] C_MEMADR  = 18'b0_0_00_0_0_0_0_0_0_0_1_10_00_0_0;
    localparam logic [17:0] C_MEMRD   = 18'b0_0_00_1_1_0_0_0_0_0_0_00_00_0_0;
    localparam logic [17:0] C_MEMWB   = 18'b0_0_00_0_0_0_0_1_0_1_0_00_00_1_0;
    localparam logic [17:0] C_MEMWR_R = 18'b0_0_00_1_0_1_0_0_0_0_0_00_00_1_0;
    localparam logic [17:0] C_EXEC    = 18'b0_0_00_0_0_0_0_0_0_0_1_00_10_0_0;
    localparam logic [17:0] C_ALUWB   = 18'b0_0_00_0_0_0_0_0_1_1_0_00_00_1_0;
    localparam logic [17:0] C_BRANCH  = 18'b0_1_01_0_0_0_0_0_0_0_1_00_01_1_0;
    localparam logic [17:0] C_JUMP    = 18'b1_0_10_0_0_0_0_0_0_0_0_00_00_1_0;
    localparam logic [17:0] C_ADDIWB  = 18'b0_0_00_0_0_0_0_0_0_1_0_00_00_1_0;
    localparam logic [17:0] C_ERROR   = 18'b0_0_00_0_0_0_0_0_0_0_0_00_00_0_1;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, bus_error;
    logic [1:0] pc_src, alu_src_b, alu_op;
    logic [3:0] state;
`ifdef ILLEGAL_TRAP_EN
    logic       illegal_op;
`endif
    logic [17:0] ctrl;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mc_control_fsm #(.MEM_TIMEOUT(4), .CNT_W(8), .STATE_W(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .instr_done(instr_done), .bus_error(bus_error),
`ifdef ILLEGAL_TRAP_EN
        .illegal_op(illegal_op),
`endif
        .state(state)
    );

    assign ctrl = {pc_write, pc_write_cond, pc_src, iord, mem_read, mem_write,
                   ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                   alu_src_b, alu_op, instr_done, bus_error};

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; opcode = 6'b000000; mem_ready = 1'b1;
        #1;
        n_chk++; if (state !== S_INIT) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", state, S_INIT); end
        n_chk++; if (ctrl !== C_ZERO) begin n_fail++; $display("FAIL reset_ctrl: got %b want %b", ctrl, C_ZERO); end
        cyc(); cyc();
        reset = 1'b0;
        #1;
        n_chk++; if (state !== S_INIT) begin n_fail++; $display("FAIL reset_hold_init: got %0d want %0d", state, S_INIT); end
        cyc();
        n_chk++; if (state !== S_FETCH) begin n_fail++; $display("FAIL reset_to_fetch: got %0d want %0d", state, S_FETCH); end
        n_chk++; if (ctrl !== C_FETCH_R) begin n_fail++; $display("FAIL reset_fetch_ctrl: got %b want %b", ctrl, C_FETCH_R); end
    endtask

    task automatic test_rtype();
        logic [3:0]  es [5] = '{S_FETCH, S_DECODE, S_EXEC, S_ALUWB, S_FETCH};
        logic [17:0] ec [5] = '{C_FETCH_R, C_DEC, C_EXEC, C_ALUWB, C_FETCH_R};
        opcode = 6'b000000; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            // Opcode changes after DECODE must be ignored.
            if (i == 2) opcode = 6'b000010;
            #1;
            n_chk++; if (state !== es[i]) begin n_fail++; $display("FAIL rtype_state[%0d]: got %0d want %0d", i, state, es[i]); end
            n_chk++; if (ctrl !== ec[i]) begin n_fail++; $display("FAIL rtype_ctrl[%0d]: got %b want %b", i, ctrl, ec[i]); end
            if (i < 4) cyc();
        end
    endtask

    task automatic test_lw_stall();
        logic [3:0]  es [8]  = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMRD, S_MEMRD, S_MEMRD, S_MEMWB};
        logic [17:0] ec [8]  = '{C_FETCH_R, C_DEC, C_MEMADR, C_MEMRD, C_MEMRD, C_MEMRD, C_MEMRD, C_MEMWB};
        logic        rdy [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        opcode = 6'b100011;
        for (int i = 0; i < 8; i++) begin
            mem_ready = rdy[i];
            #1;
            n_chk++; if (state !== es[i]) begin n_fail++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, state, es[i]); end
            n_chk++; if (ctrl !== ec[i]) begin n_fail++; $display("FAIL lw_ctrl[%0d]: got %b want %b", i, ctrl, ec[i]); end
            cyc();
        end
        #1;
        n_chk++; if (state !== S_FETCH) begin n_fail++; $display("FAIL lw_back_to_fetch: got %0d want %0d", state, S_FETCH); end
    endtask

    task automatic test_reset_mid();
        opcode = 6'b100011; mem_ready = 1'b1;
        cyc(); cyc(); cyc();
        mem_ready = 1'b0;
        #1;
        n_chk++; if (state !== S_MEMRD) begin n_fail++; $display("FAIL midrst_in_memrd: got %0d want %0d", state, S_MEMRD); end
        reset = 1'b1;
        #1;
        n_chk++; if (state !== S_INIT) begin n_fail++; $display("FAIL midrst_async: got %0d want %0d", state, S_INIT); end
        n_chk++; if (ctrl !== C_ZERO) begin n_fail++; $display("FAIL midrst_ctrl: got %b want %b", ctrl, C_ZERO); end
        cyc();
        mem_ready = 1'b1;
        reset = 1'b0;
        #1;
        n_chk++; if (state !== S_INIT) begin n_fail++; $display("FAIL midrst_init: got %0d want %0d", state, S_INIT); end
        cyc();
        n_chk++; if (state !== S_FETCH) begin n_fail++; $display("FAIL midrst_fetch: got %0d want %0d", state, S_FETCH); end
        n_chk++; if (ctrl !== C_FETCH_R) begin n_fail++; $display("FAIL midrst_fetch_ctrl: got %b want %b", ctrl, C_FETCH_R); end
    endtask

    task automatic test_sw_addi();
        logic [3:0]  es [10] = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMWR, S_FETCH,
                                 S_DECODE, S_ADDIEX, S_ADDIWB, S_FETCH, S_FETCH};
        logic [17:0] ec [10] = '{C_FETCH_R, C_DEC, C_MEMADR, C_MEMWR_R, C_FETCH_R,
                                 C_DEC, C_MEMADR, C_ADDIWB, C_FETCH_R, C_FETCH_R};
        mem_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            opcode = (i < 4) ? 6'b101011 : 6'b001000;
            #1;
            n_chk++; if (state !== es[i]) begin n_fail++; $display("FAIL swaddi_state[%0d]: got %0d want %0d", i, state, es[i]); end
            n_chk++; if (ctrl !== ec[i]) begin n_fail++; $display("FAIL swaddi_ctrl[%0d]: got %b want %b", i, ctrl, ec[i]); end
            if (i < 8) cyc();
        end
    endtask

    task automatic test_branch_jump();
        logic [3:0]  es [7] = '{S_FETCH, S_DECODE, S_BRANCH, S_FETCH, S_DECODE, S_JUMP, S_FETCH};
        logic [17:0] ec [7] = '{C_FETCH_R, C_DEC, C_BRANCH, C_FETCH_R, C_DEC, C_JUMP, C_FETCH_R};
        mem_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            opcode = (i < 3) ? 6'b000100 : 6'b000010;
            #1;
            n_chk++; if (state !== es[i]) begin n_fail++; $display("FAIL brj_state[%0d]: got %0d want %0d", i, state, es[i]); end
            n_chk++; if (ctrl !== ec[i]) begin n_fail++; $display("FAIL brj_ctrl[%0d]: got %b want %b", i, ctrl, ec[i]); end
            if (i < 6) cyc();
        end
    endtask

    task automatic test_timeout_boundary();
        logic [3:0]  es [5]  = '{S_FETCH, S_FETCH, S_FETCH, S_FETCH, S_DECODE};
        logic [17:0] ec [5]  = '{C_FETCH_W, C_FETCH_W, C_FETCH_W, C_FETCH_R, C_DEC};
        logic        rdy [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        opcode = 6'b000000;
        for (int i = 0; i < 5; i++) begin
            mem_ready = rdy[i];
            #1;
            n_chk++; if (state !== es[i]) begin n_fail++; $display("FAIL tmo_edge_state[%0d]: got %0d want %0d", i, state, es[i]); end
            n_chk++; if (ctrl !== ec[i]) begin n_fail++; $display("FAIL tmo_edge_ctrl[%0d]: got %b want %b", i, ctrl, ec[i]); end
            cyc();
        end
        // EXEC -> ALUWB -> FETCH
        cyc(); cyc();
        n_chk++; if (state !== S_FETCH) begin n_fail++; $display("FAIL tmo_edge_resume: got %0d want %0d", state, S_FETCH); end
    endtask

    task automatic test_illegal();
        opcode = 6'b111111; mem_ready = 1'b1;
        #1;
        n_chk++; if (state !== S_FETCH) begin n_fail++; $display("FAIL ill_fetch: got %0d want %0d", state, S_FETCH); end
        cyc();
        n_chk++; if (state !== S_DECODE) begin n_fail++; $display("FAIL ill_decode: got %0d want %0d", state, S_DECODE); end
`ifdef ILLEGAL_TRAP_EN
        n_chk++; if (ctrl !== C_DEC) begin n_fail++; $display("FAIL ill_decode_ctrl: got %b want %b", ctrl, C_DEC); end
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_chk++; if (state !== S_TRAP) begin n_fail++; $display("FAIL ill_trap_state[%0d]: got %0d want %0d", i, state, S_TRAP); end
            n_chk++; if (ctrl !== C_ZERO) begin n_fail++; $display("FAIL ill_trap_ctrl[%0d]: got %b want %b", i, ctrl, C_ZERO); end
            n_chk++; if (illegal_op !== 1'b1) begin n_fail++; $display("FAIL ill_trap_flag[%0d]: got %b want 1", i, illegal_op); end
        end
        reset = 1'b1;
        #1;
        n_chk++; if (illegal_op !== 1'b0) begin n_fail++; $display("FAIL ill_flag_reset: got %b want 0", illegal_op); end
        reset = 1'b0;
        cyc();
`else
        n_chk++; if (ctrl !== C_DEC_NOP) begin n_fail++; $display("FAIL ill_nop_ctrl: got %b want %b", ctrl, C_DEC_NOP); end
        cyc();
`endif
        n_chk++; if (state !== S_FETCH) begin n_fail++; $display("FAIL ill_after: got %0d want %0d", state, S_FETCH); end
    endtask

    task automatic test_timeout();
        opcode = 6'b000000; mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_chk++; if (state !== S_FETCH) begin n_fail++; $display("FAIL tmo_fetch[%0d]: got %0d want %0d", i, state, S_FETCH); end
            cyc();
        end
        n_chk++; if (state !== S_ERROR) begin n_fail++; $display("FAIL tmo_error: got %0d want %0d", state, S_ERROR); end
        n_chk++; if (ctrl !== C_ERROR) begin n_fail++; $display("FAIL tmo_error_ctrl: got %b want %b", ctrl, C_ERROR); end
        mem_ready = 1'b1;
        cyc(); cyc(); cyc();
        n_chk++; if (state !== S_ERROR) begin n_fail++; $display("FAIL tmo_sticky_state: got %0d want %0d", state, S_ERROR); end
        n_chk++; if (bus_error !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky_flag: got %b want 1", bus_error); end
        reset = 1'b1;
        #1;
        n_chk++; if (bus_error !== 1'b0) begin n_fail++; $display("FAIL tmo_flag_reset: got %b want 0", bus_error); end
        n_chk++; if (state !== S_INIT) begin n_fail++; $display("FAIL tmo_state_reset: got %0d want %0d", state, S_INIT); end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_stall();
        test_reset_mid();
        test_sw_addi();
        test_branch_jump();
        test_timeout_boundary();
        test_illegal();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
